// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage MIPS pipeline.
// Combinational pipeline-register controls come from the FSM state and the
// hazard inputs. Event counters and the sticky error flag are registered.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_usesRt,
    input  logic             idex_memRead,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_memRead,
    input  logic             exmem_memWrite,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             dmem_req,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] wait_count,
    output logic [CNT_W-1:0] flush_count
);

    // Wide enough to hold MEM_TIMEOUT itself.
    localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_error_q, mem_error_d;
    logic            mem_acc;
    logic            load_use;
    logic            freeze;
    logic            apply_rules;
    // Counter increment strobes: [0] load-use stall, [1] memory wait, [2] branch flush.
    logic [2:0]      cnt_inc;

    assign mem_acc  = exmem_memRead | exmem_memWrite;
    assign load_use = idex_memRead && (idex_rt != 5'd0) &&
                      ((idex_rt == id_rs) || (id_usesRt && (idex_rt == id_rt)));

    // Next-state logic and same-cycle pipeline controls, in priority order.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        freeze      = 1'b0;
        apply_rules = 1'b0;
        cnt_inc     = 3'b000;
        dmem_req    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_acc) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        apply_rules = 1'b1;
                    end else begin
                        freeze     = 1'b1;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WC_W'(1);
                        cnt_inc[1] = 1'b1;
                    end
                end else begin
                    apply_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    apply_rules = 1'b1;
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
                        state_d     = ERR;
                        mem_error_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                        cnt_inc[1] = 1'b1;
                    end
                end
            end
            ERR: begin
                freeze      = 1'b1;
                mem_error_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (apply_rules) begin
            if (branch_taken) begin
                // The dependent instruction is squashed, so a load-use hit is moot.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                cnt_inc[2] = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                cnt_inc[0] = 1'b1;
            end
        end

        // Reset holds the whole pipeline cleared and idle.
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            dmem_req    = 1'b0;
            cnt_inc     = 3'b000;
        end
    end

    // FSM state, wait counter and sticky error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign mem_error = mem_error_q;

    // Three identical saturating event counters.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Increment unless already at the all-ones ceiling.
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Counter register.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign stall_count = g_cnt[0].cnt_q;
    assign wait_count  = g_cnt[1].cnt_q;
    assign flush_count = g_cnt[2].cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table vectors, hand sequences for the
// multi-cycle corners, and random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MT   = 4;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    // Control vector bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_flush dmem_req
    localparam logic [7:0] C_IDLE   = 8'b1101_0100;
    localparam logic [7:0] C_LU     = 8'b0001_1100;
    localparam logic [7:0] C_BR     = 8'b1111_1100;
    localparam logic [7:0] C_MEMOK  = 8'b1101_0101;
    localparam logic [7:0] C_MEMLU  = 8'b0001_1101;
    localparam logic [7:0] C_MEMBR  = 8'b1111_1101;
    localparam logic [7:0] C_FROZEN = 8'b0000_0011;
    localparam logic [7:0] C_ERR    = 8'b0000_0010;
    localparam logic [7:0] C_RST    = 8'b0010_1010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [4:0]    id_rs, id_rt, idex_rt;
    logic          id_usesRt, idex_memRead, exmem_memRead, exmem_memWrite;
    logic          dmem_ready, branch_taken;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, memwb_flush, dmem_req, mem_error;
    logic [CW-1:0] stall_count, wait_count, flush_count;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
        .idex_memRead(idex_memRead), .idex_rt(idex_rt),
        .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
        .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_flush(memwb_flush), .dmem_req(dmem_req), .mem_error(mem_error),
        .stall_count(stall_count), .wait_count(wait_count), .flush_count(flush_count)
    );

    logic [7:0] dut_ctl;
    assign dut_ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, dmem_req};

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       idex_mr;
        logic [4:0] idex_rt;
        logic       mr;
        logic       mw;
        logic       rdy;
        logic       br;
    } in_t;

    typedef struct {
        in_t        i;
        logic [7:0] e;
        string      nm;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Behavioural model: length of the current unserviced-access streak,
    // a dead flag once the streak exceeds the timeout, and clamped counters.
    int m_streak = 0;
    bit m_dead   = 1'b0;
    int m_stall  = 0;
    int m_wait   = 0;
    int m_flush  = 0;

    function automatic in_t mk(input logic rst, input int rs, input int rt, input logic ur,
                               input logic imr, input int irt, input logic mr, input logic mw,
                               input logic rdy, input logic br);
        in_t x;
        x.rst = rst; x.rs = 5'(rs); x.rt = 5'(rt); x.uses_rt = ur;
        x.idex_mr = imr; x.idex_rt = 5'(irt); x.mr = mr; x.mw = mw;
        x.rdy = rdy; x.br = br;
        return x;
    endfunction

    function automatic bit m_lu(input in_t x);
        return x.idex_mr && (x.idex_rt != 0) &&
               ((x.idex_rt == x.rs) || (x.uses_rt && (x.idex_rt == x.rt)));
    endfunction

    function automatic bit m_req(input in_t x);
        return (m_streak > 0) || x.mr || x.mw;
    endfunction

    function automatic logic [7:0] model_ctl(input in_t x);
        bit frozen;
        if (x.rst) return C_RST;
        if (m_dead) return C_ERR;
        frozen = m_req(x) && !x.rdy;
        if (frozen) return C_FROZEN;
        if (x.br) return m_req(x) ? C_MEMBR : C_BR;
        if (m_lu(x)) return m_req(x) ? C_MEMLU : C_LU;
        return m_req(x) ? C_MEMOK : C_IDLE;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_commit(input in_t x);
        if (x.rst) begin
            m_streak = 0; m_dead = 1'b0; m_stall = 0; m_wait = 0; m_flush = 0;
        end else if (!m_dead) begin
            if (m_req(x) && !x.rdy) begin
                if (m_streak + 1 > MT) begin
                    m_dead = 1'b1;
                end else begin
                    m_streak = m_streak + 1;
                    m_wait   = sat_inc(m_wait);
                end
            end else begin
                m_streak = 0;
                if (x.br) m_flush = sat_inc(m_flush);
                else if (m_lu(x)) m_stall = sat_inc(m_stall);
            end
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, got, got, exp, exp, $time);
        end
    endtask

    // One clock: drive, check combinational controls mid-cycle, clock, check registered state.
    task automatic step(input in_t x, input logic [7:0] e, input string nm);
        reset = x.rst; id_rs = x.rs; id_rt = x.rt; id_usesRt = x.uses_rt;
        idex_memRead = x.idex_mr; idex_rt = x.idex_rt;
        exmem_memRead = x.mr; exmem_memWrite = x.mw;
        dmem_ready = x.rdy; branch_taken = x.br;
        #2;
        chk({nm, ".ctl"}, int'(dut_ctl), int'(e));
        $display("[TB] %-10s rst=%0b rs=%0d rt=%0d ur=%0b imr=%0b irt=%0d mr=%0b mw=%0b rdy=%0b br=%0b ctl=%08b",
                 nm, x.rst, x.rs, x.rt, x.uses_rt, x.idex_mr, x.idex_rt, x.mr, x.mw, x.rdy, x.br, dut_ctl);
        @(posedge clk);
        #1;
        model_commit(x);
        chk({nm, ".mem_error"},   int'(mem_error),   int'(m_dead));
        chk({nm, ".stall_count"}, int'(stall_count), m_stall);
        chk({nm, ".wait_count"},  int'(wait_count),  m_wait);
        chk({nm, ".flush_count"}, int'(flush_count), m_flush);
    endtask

    task automatic mstep(input in_t x, input string nm);
        step(x, model_ctl(x), nm);
    endtask

    vec_t vecs[$];
    in_t  rst_v, idle_v, rd_wait, rd_ok, lu_v;

    initial begin
        rst_v   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd_wait = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rd_ok   = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        lu_v    = mk(0, 8, 0, 0, 1, 8, 0, 0, 0, 0);

        step(rst_v, C_RST, "reset0");
        step(rst_v, C_RST, "reset1");

        // Single-cycle vectors; none of them leaves the RUN state.
        vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_IDLE,  "idle"});
        vecs.push_back('{mk(0, 8, 0, 0, 1, 8, 0, 0, 0, 0), C_LU,    "lu_rs"});
        vecs.push_back('{mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), C_IDLE,  "lu_r0"});
        vecs.push_back('{mk(0, 3, 9, 1, 1, 9, 0, 0, 0, 0), C_LU,    "lu_rt"});
        vecs.push_back('{mk(0, 3, 9, 0, 1, 9, 0, 0, 0, 0), C_IDLE,  "rt_nouse"});
        vecs.push_back('{mk(0, 8, 0, 0, 0, 8, 0, 0, 0, 0), C_IDLE,  "no_load"});
        vecs.push_back('{mk(0, 8, 0, 0, 1, 8, 0, 0, 0, 1), C_BR,    "br_lu"});
        vecs.push_back('{mk(0, 1, 2, 1, 0, 5, 0, 0, 0, 1), C_BR,    "br"});
        vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_MEMOK, "st_zero"});
        vecs.push_back('{mk(0, 4, 0, 0, 1, 4, 1, 0, 1, 0), C_MEMLU, "ld_lu"});
        vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1), C_MEMBR, "ld_br"});
        for (int i = 0; i < vecs.size(); i++) step(vecs[i].i, vecs[i].e, vecs[i].nm);
        chk("tbl.stall_count", int'(stall_count), 3);
        chk("tbl.flush_count", int'(flush_count), 3);
        chk("tbl.wait_count",  int'(wait_count),  0);

        // Memory wait: three unserviced cycles then completion.
        step(rst_v, C_RST, "reset");
        for (int i = 0; i < 3; i++) step(rd_wait, C_FROZEN, "memwait");
        step(rd_ok, C_MEMOK, "memdone");
        chk("memwait.wait_count", int'(wait_count), 3);
        step(idle_v, C_IDLE, "after_wait");

        // Timeout: MT+1 unserviced cycles reach the error state.
        step(rst_v, C_RST, "reset");
        for (int i = 0; i < MT + 1; i++) step(rd_wait, C_FROZEN, "timeout");
        chk("timeout.mem_error", int'(mem_error), 1);
        chk("timeout.wait_count", int'(wait_count), MT);
        step(rd_ok, C_ERR, "err_hold");
        step(lu_v, C_ERR, "err_hold");
        step(rst_v, C_RST, "err_reset");
        chk("err_reset.mem_error", int'(mem_error), 0);
        chk("err_reset.wait_count", int'(wait_count), 0);
        step(idle_v, C_IDLE, "err_run");

        // Reset in the middle of a memory wait.
        for (int i = 0; i < 2; i++) step(rd_wait, C_FROZEN, "midwait");
        step(rst_v, C_RST, "mid_reset");
        step(idle_v, C_IDLE, "mid_run");
        step(rd_ok, C_MEMOK, "mid_ok");

        // Saturation of the 3-bit stall counter.
        step(rst_v, C_RST, "reset");
        for (int i = 0; i < 10; i++) step(lu_v, C_LU, "sat_lu");
        chk("sat.stall_count", int'(stall_count), CMAX);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            in_t x;
            x.rst     = ($urandom_range(0, 39) == 0);
            x.rs      = 5'($urandom_range(0, 3));
            x.rt      = 5'($urandom_range(0, 3));
            x.uses_rt = 1'($urandom_range(0, 1));
            x.idex_mr = 1'($urandom_range(0, 1));
            x.idex_rt = 5'($urandom_range(0, 3));
            x.mr      = ($urandom_range(0, 3) == 0);
            x.mw      = ($urandom_range(0, 5) == 0);
            x.rdy     = 1'($urandom_range(0, 1));
            x.br      = ($urandom_range(0, 4) == 0);
            mstep(x, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and applies taken-branch flushes.
- Freezes the pipeline while a multi-cycle data-memory access is outstanding, with timeout detection and saturating event counters.

Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before declaring a memory error (≥1).
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_usesRt  in  1  ID instruction reads rt as a source.
- idex_memRead  in  1  the instruction in EX is a load.
- idex_rt  in  5  destination rt of the instruction in EX.
- exmem_memRead  in  1  load in the MEM stage.
- exmem_memWrite  in  1  store in the MEM stage.
- dmem_ready  in  1  data memory completes the current access this cycle.
- branch_taken  in  1  branch/jump resolved taken in EX.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear to NOP.
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX clear control bits (bubble).
- exmem_en  out  1  EX/MEM load enable.
- memwb_flush  out  1  MEM/WB clear control bits (bubble).
- dmem_req  out  1  data-memory request strobe.
- mem_error  out  1  sticky timeout flag.
- stall_count  out  CNT_W  load-use stall cycles.
- wait_count  out  CNT_W  memory-wait cycles.
- flush_count  out  CNT_W  taken-branch flushes.

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- FSM states RUN, MEM_WAIT, ERR.
- Reset:
  - state=RUN, wait_cnt=0, mem_error=0, all counters=0.
  - While reset is high, outputs are forced: all enables=0, ifid_flush=idex_flush=memwb_flush=1, dmem_req=0.
- Control outputs are combinational from state and inputs (same-cycle effect). Counters and mem_error are registered.
- mem_acc = exmem_memRead | exmem_memWrite.
- load_use = idex_memRead & (idex_rt≠0) & ((idex_rt==id_rs) | (id_usesRt & idex_rt==id_rt)).
- Defaults: all enables=1, all flushes=0.
- Priority, highest first: ERR > memory freeze > branch flush > load-use stall.
- RUN with mem_acc:
  - dmem_req=1.
  - If dmem_ready: no stall; the remaining rules apply.
  - Else: freeze. pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, branch and load-use ignored; next state MEM_WAIT, wait_cnt←1, wait_count+1.
- MEM_WAIT:
  - dmem_req=1; freeze as above.
  - If dmem_ready: that cycle un-freezes (enables=1, memwb_flush=0); branch/load-use rules apply normally; next state RUN, wait_cnt←0.
  - Else if wait_cnt==MEM_TIMEOUT: next state ERR, mem_error←1.
  - Else wait_cnt+1, wait_count+1.
  - Net effect: an access unserviced for MEM_TIMEOUT+1 consecutive cycles enters ERR.
- Branch (not frozen, branch_taken=1):
  - ifid_flush=1, idex_flush=1, pc_en=1; flush_count+1.
  - A simultaneous load_use is ignored, since the dependent instruction is flushed.
- Load-use (not frozen, no branch):
  - pc_en=0, ifid_en=0, idex_flush=1; stall_count+1.
  - This gives a one-cycle bubble; the following cycle idex_memRead is 0 and the stall naturally clears.
- ERR:
  - Permanent freeze: all enables=0, memwb_flush=1, dmem_req=0, mem_error=1.
  - Exits only via reset.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN on the next edge; dmem_req drops in the reset cycle.
- No registered latency on controls; counter and flag updates are visible one cycle after the event.

Test Plan:
- Load-use: idex_memRead=1, idex_rt=8, id_rs=8 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_count=1 next cycle. Repeat with idex_rt=0 -> no stall.
- Branch vs hazard: branch_taken=1 together with the load-use condition above -> ifid_flush=idex_flush=1, pc_en=1; flush_count=1, stall_count unchanged.
- Memory wait: exmem_memRead=1, dmem_ready low for 3 cycles then high -> dmem_req=1 for 4 cycles, enables=0 and memwb_flush=1 for the first 3 cycles, all enabled in the 4th; wait_count=3; state RUN.
- Zero-wait access: exmem_memWrite=1 with dmem_ready=1 same cycle -> no freeze, wait_count=0.
- Timeout with MEM_TIMEOUT=4: memRead held with dmem_ready never high -> mem_error rises after 5 unserviced cycles; pipeline stays frozen; reset pulse -> mem_error=0, state RUN, counters 0.
- Saturation with CNT_W=3: 10 load-use stalls -> stall_count=7.
